// File: rtl/mandelbrot_pkg.sv
// Shared types and sizing for the Mandelbrot frame pipeline.
package mandelbrot_pkg;

  localparam int unsigned INTEGER_BITS    = 8;
  localparam int unsigned FRACTIONAL_BITS = 24;
  localparam int unsigned DATA_WIDTH      = INTEGER_BITS + FRACTIONAL_BITS;
  localparam int unsigned MAX_ITER_WIDTH  = 16;
  localparam int unsigned COORD_WIDTH     = 11;

  typedef logic signed [DATA_WIDTH-1:0] fixed_t;
  typedef logic [MAX_ITER_WIDTH-1:0]    iter_t;
  typedef logic [COORD_WIDTH-1:0]       coord_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUTPUT,
    S_FINISH
  } sched_state_t;

endpackage

// File: rtl/mandelbrot_raster_counter.sv
// Raster-order pixel counters with incremental Q-format coordinate stepping.
module mandelbrot_raster_counter #(
  parameter int unsigned DATA_WIDTH  = mandelbrot_pkg::DATA_WIDTH,
  parameter int unsigned COORD_WIDTH = mandelbrot_pkg::COORD_WIDTH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         load,
  input  logic                         advance,
  input  logic [COORD_WIDTH-1:0]       width,
  input  logic [COORD_WIDTH-1:0]       height,
  input  logic signed [DATA_WIDTH-1:0] x_min,
  input  logic signed [DATA_WIDTH-1:0] y_max,
  input  logic signed [DATA_WIDTH-1:0] step,
  output logic [COORD_WIDTH-1:0]       px,
  output logic [COORD_WIDTH-1:0]       py,
  output logic signed [DATA_WIDTH-1:0] cur_x,
  output logic signed [DATA_WIDTH-1:0] cur_y,
  output logic                         last
);

  logic [COORD_WIDTH-1:0]       width_q;
  logic [COORD_WIDTH-1:0]       height_q;
  logic signed [DATA_WIDTH-1:0] x_min_q;
  logic signed [DATA_WIDTH-1:0] step_q;
  logic                         row_end;

  assign row_end = (px == width_q - COORD_WIDTH'(1));
  assign last    = row_end && (py == height_q - COORD_WIDTH'(1));

  // Row starts reload cur_x from x_min so stepping error never carries across rows.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      width_q  <= '0;
      height_q <= '0;
      x_min_q  <= '0;
      step_q   <= '0;
      px       <= '0;
      py       <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
    end else if (load) begin
      width_q  <= width;
      height_q <= height;
      x_min_q  <= x_min;
      step_q   <= step;
      px       <= '0;
      py       <= '0;
      cur_x    <= x_min;
      cur_y    <= y_max;
    end else if (advance) begin
      if (!row_end) begin
        px    <= px + COORD_WIDTH'(1);
        cur_x <= cur_x + step_q;
      end else begin
        px    <= '0;
        py    <= py + COORD_WIDTH'(1);
        cur_x <= x_min_q;
        cur_y <= cur_y - step_q;
      end
    end
  end

endmodule

// File: rtl/mandelbrot_pixel_scheduler.sv
// Frame sequencer: issues one pixel job at a time to the iteration core and
// forwards each result, tagged with its coordinates, over valid/ready.
module mandelbrot_pixel_scheduler #(
  parameter int unsigned DATA_WIDTH     = mandelbrot_pkg::DATA_WIDTH,
  parameter int unsigned MAX_ITER_WIDTH = mandelbrot_pkg::MAX_ITER_WIDTH,
  parameter int unsigned COORD_WIDTH    = mandelbrot_pkg::COORD_WIDTH
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         frame_start_i,
  input  logic [COORD_WIDTH-1:0]       width_i,
  input  logic [COORD_WIDTH-1:0]       height_i,
  input  logic signed [DATA_WIDTH-1:0] x_min_i,
  input  logic signed [DATA_WIDTH-1:0] y_max_i,
  input  logic signed [DATA_WIDTH-1:0] step_i,
  input  logic [MAX_ITER_WIDTH-1:0]    max_iter_i,
  output logic                         core_start_o,
  output logic signed [DATA_WIDTH-1:0] core_x0_o,
  output logic signed [DATA_WIDTH-1:0] core_y0_o,
  output logic [MAX_ITER_WIDTH-1:0]    core_max_iter_o,
  input  logic [MAX_ITER_WIDTH-1:0]    core_iter_i,
  input  logic                         core_done_i,
  output logic                         pix_valid_o,
  input  logic                         pix_ready_i,
  output logic [COORD_WIDTH-1:0]       pix_x_o,
  output logic [COORD_WIDTH-1:0]       pix_y_o,
  output logic [MAX_ITER_WIDTH-1:0]    pix_iter_o,
  output logic                         pix_last_o,
  output logic                         busy_o,
  output logic                         frame_done_o
);

  import mandelbrot_pkg::*;

  sched_state_t state_q;
  sched_state_t state_d;

  logic                         load;
  logic                         advance;
  logic                         capture;
  logic [COORD_WIDTH-1:0]       px;
  logic [COORD_WIDTH-1:0]       py;
  logic signed [DATA_WIDTH-1:0] cur_x;
  logic signed [DATA_WIDTH-1:0] cur_y;
  logic                         last;

  logic [MAX_ITER_WIDTH-1:0]    max_iter_q;
  logic [COORD_WIDTH-1:0]       pix_x_q;
  logic [COORD_WIDTH-1:0]       pix_y_q;
  logic [MAX_ITER_WIDTH-1:0]    pix_iter_q;
  logic                         pix_last_q;

  mandelbrot_raster_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .COORD_WIDTH(COORD_WIDTH)
  ) u_raster (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load   (load),
    .advance(advance),
    .width  (width_i),
    .height (height_i),
    .x_min  (x_min_i),
    .y_max  (y_max_i),
    .step   (step_i),
    .px     (px),
    .py     (py),
    .cur_x  (cur_x),
    .cur_y  (cur_y),
    .last   (last)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_start_i) begin
          load    = 1'b1;
          state_d = ((width_i == '0) || (height_i == '0)) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_done_i) begin
          capture = 1'b1;
          state_d = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (pix_ready_i) begin
          if (pix_last_q) begin
            state_d = S_FINISH;
          end else begin
            advance = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      max_iter_q <= '0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      pix_iter_q <= '0;
      pix_last_q <= 1'b0;
    end else begin
      if (load) begin
        max_iter_q <= max_iter_i;
      end
      if (capture) begin
        pix_x_q    <= px;
        pix_y_q    <= py;
        pix_iter_q <= core_iter_i;
        pix_last_q <= last;
      end
    end
  end

  // cur_x/cur_y only move on accept, so they already hold the job stable from ISSUE onward.
  assign core_start_o    = (state_q == S_ISSUE);
  assign core_x0_o       = cur_x;
  assign core_y0_o       = cur_y;
  assign core_max_iter_o = max_iter_q;

  assign pix_valid_o  = (state_q == S_OUTPUT);
  assign pix_x_o      = pix_x_q;
  assign pix_y_o      = pix_y_q;
  assign pix_iter_o   = pix_iter_q;
  assign pix_last_o   = pix_last_q;

  assign busy_o       = (state_q != S_IDLE);
  assign frame_done_o = (state_q == S_FINISH);

endmodule

// File: tb/tb_mandelbrot_pixel_scheduler.sv
// Bench for mandelbrot_pixel_scheduler: behavioural core model plus raster reference.
module tb_mandelbrot_pixel_scheduler;

  localparam int DW = 32;
  localparam int IW = 16;
  localparam int CW = 11;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 frame_start = 1'b0;
  logic [CW-1:0]        width = '0;
  logic [CW-1:0]        height = '0;
  logic signed [DW-1:0] x_min = '0;
  logic signed [DW-1:0] y_max = '0;
  logic signed [DW-1:0] step = '0;
  logic [IW-1:0]        max_iter = '0;
  logic                 core_start;
  logic signed [DW-1:0] core_x0;
  logic signed [DW-1:0] core_y0;
  logic [IW-1:0]        core_max_iter;
  logic [IW-1:0]        core_iter = '0;
  logic                 core_done = 1'b0;
  logic                 pix_valid;
  logic                 pix_ready = 1'b0;
  logic [CW-1:0]        pix_x;
  logic [CW-1:0]        pix_y;
  logic [IW-1:0]        pix_iter;
  logic                 pix_last;
  logic                 busy;
  logic                 frame_done;

  int total = 0;
  int bad = 0;

  int            core_lat = 3;
  bit            iter_fixed = 1'b0;
  logic [IW-1:0] iter_val = '0;
  logic [IW-1:0] iter_q[$];
  int            core_cnt = 0;

  mandelbrot_pixel_scheduler #(
    .DATA_WIDTH    (DW),
    .MAX_ITER_WIDTH(IW),
    .COORD_WIDTH   (CW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .frame_start_i  (frame_start),
    .width_i        (width),
    .height_i       (height),
    .x_min_i        (x_min),
    .y_max_i        (y_max),
    .step_i         (step),
    .max_iter_i     (max_iter),
    .core_start_o   (core_start),
    .core_x0_o      (core_x0),
    .core_y0_o      (core_y0),
    .core_max_iter_o(core_max_iter),
    .core_iter_i    (core_iter),
    .core_done_i    (core_done),
    .pix_valid_o    (pix_valid),
    .pix_ready_i    (pix_ready),
    .pix_x_o        (pix_x),
    .pix_y_o        (pix_y),
    .pix_iter_o     (pix_iter),
    .pix_last_o     (pix_last),
    .busy_o         (busy),
    .frame_done_o   (frame_done)
  );

  always #5 clk = ~clk;

  // Core model: done stays high until the cycle after the next start, then
  // rises again core_lat cycles after that start.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      core_done = 1'b0;
      core_cnt  = 0;
    end else if (core_start === 1'b1) begin
      core_cnt = core_lat;
    end else if (core_cnt > 0) begin
      core_done = 1'b0;
      core_cnt--;
      if (core_cnt == 0) begin
        core_iter = iter_fixed ? iter_val : IW'($urandom);
        core_done = 1'b1;
        iter_q.push_back(core_iter);
      end
    end
  end

  // mode: 0 always ready, 1 random ready, 2 hold ready low 5 cycles on the second pixel
  task automatic run_frame(input int w, input int h, input logic signed [DW-1:0] xm,
                           input logic signed [DW-1:0] ym, input logic signed [DW-1:0] st,
                           input logic [IW-1:0] mi, input int mode, input bit disturb);
    int n, jobs, outs, dones, cyc, last_acc, last_start, stall;
    bit pend, acc;
    logic [CW-1:0] ex_px, ex_py;
    logic [IW-1:0] ex_it;
    logic ex_last;
    logic signed [DW-1:0] ex, ey;
    n = w * h; jobs = 0; outs = 0; dones = 0; last_acc = -1; last_start = -100;
    stall = 0; pend = 1'b0;
    ex_px = '0; ex_py = '0; ex_it = '0; ex_last = 1'b0;
    iter_q.delete();
    @(negedge clk);
    width = CW'(w); height = CW'(h); x_min = xm; y_max = ym; step = st; max_iter = mi;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    cyc = 1;
    while (dones == 0 && cyc < 3000) begin
      if (disturb && cyc == 2) begin
        frame_start = 1'b1; width = 11'd7; height = 11'd5;
        x_min = x_min + 32'sh0100_0000; y_max = y_max - 32'sh0030_0000;
        step = step ^ 32'sh0000_0110; max_iter = max_iter + 16'd5;
      end
      if (disturb && cyc == 3) frame_start = 1'b0;
      case (mode)
        0: pix_ready = 1'b1;
        1: pix_ready = ($urandom_range(0, 2) != 0);
        default: pix_ready = !(pix_valid === 1'b1 && outs == 1 && stall < 5);
      endcase
      if (mode == 2 && pix_valid === 1'b1 && outs == 1 && stall < 5) stall++;
      acc = (pix_valid === 1'b1) && pix_ready;

      if (core_start === 1'b1) begin
        ex = xm + DW'(jobs % w) * st;
        ey = ym - DW'(jobs / w) * st;
        total++;
        if (jobs >= n || core_x0 !== ex || core_y0 !== ey) begin
          bad++;
          $display("FAIL job%0d coord: got (%h,%h) want (%h,%h)", jobs, core_x0, core_y0, ex, ey);
        end
        total++;
        if (core_max_iter !== mi) begin
          bad++;
          $display("FAIL job%0d max_iter: got %0d want %0d", jobs, core_max_iter, mi);
        end
        total++;
        if (cyc != ((jobs == 0) ? 1 : last_acc + 1)) begin
          bad++;
          $display("FAIL job%0d start latency: cycle %0d want %0d", jobs, cyc,
                   (jobs == 0) ? 1 : last_acc + 1);
        end
        total++;
        if (pix_valid !== 1'b0) begin
          bad++;
          $display("FAIL job%0d start during valid: pix_valid=%b want 0", jobs, pix_valid);
        end
        jobs++;
        last_start = cyc;
      end

      if (pix_valid === 1'b1) begin
        if (pend) begin
          total++;
          if ({pix_x, pix_y, pix_iter, pix_last} !== {ex_px, ex_py, ex_it, ex_last}) begin
            bad++;
            $display("FAIL pix%0d hold: got (%0d,%0d,%0d,%b) want (%0d,%0d,%0d,%b)", outs,
                     pix_x, pix_y, pix_iter, pix_last, ex_px, ex_py, ex_it, ex_last);
          end
        end else begin
          total++;
          if (cyc != last_start + core_lat + 1) begin
            bad++;
            $display("FAIL pix%0d valid latency: cycle %0d want %0d", outs, cyc,
                     last_start + core_lat + 1);
          end
          total++;
          if (outs >= n || outs >= iter_q.size()) begin
            bad++;
            $display("FAIL pix%0d unexpected: got valid want none (n=%0d)", outs, n);
          end else begin
            ex_px = CW'(outs % w); ex_py = CW'(outs / w);
            ex_it = iter_q[outs]; ex_last = (outs == n - 1);
            if ({pix_x, pix_y, pix_iter, pix_last} !== {ex_px, ex_py, ex_it, ex_last}) begin
              bad++;
              $display("FAIL pix%0d payload: got (%0d,%0d,%0d,%b) want (%0d,%0d,%0d,%b)", outs,
                       pix_x, pix_y, pix_iter, pix_last, ex_px, ex_py, ex_it, ex_last);
            end
          end
        end
        if (acc) begin
          outs++;
          last_acc = cyc;
        end
        pend = !acc;
      end else begin
        pend = 1'b0;
      end

      if (frame_done === 1'b1) begin
        dones++;
        total++;
        if (outs != n || cyc != last_acc + 1) begin
          bad++;
          $display("FAIL frame_done timing: cycle %0d outs %0d want cycle %0d outs %0d",
                   cyc, outs, last_acc + 1, n);
        end
      end
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL busy in frame: got %b want 1 (cycle %0d)", busy, cyc);
      end
      @(negedge clk);
      cyc++;
    end
    pix_ready = 1'b0;
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL frame end: got %0d frame_done pulses want 1 (timeout)", dones);
    end
    total++;
    if (busy !== 1'b0 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL after frame: busy=%b frame_done=%b want 0 0", busy, frame_done);
    end
    total++;
    if (jobs != n || outs != n) begin
      bad++;
      $display("FAIL counts: jobs %0d outs %0d want %0d", jobs, outs, n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({core_start, core_x0, core_y0, core_max_iter, pix_valid, pix_x, pix_y, pix_iter,
         pix_last, busy, frame_done} !== '0) begin
      bad++;
      $display("FAIL reset outputs: busy=%b valid=%b x0=%h want all 0", busy, pix_valid, core_x0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || core_start !== 1'b0) begin
      bad++;
      $display("FAIL idle after reset: busy=%b start=%b want 0 0", busy, core_start);
    end
  endtask

  task automatic test_basic_2x2;
    core_lat = 3;
    run_frame(2, 2, 32'shFE00_0000, 32'sh0100_0000, 32'sh0080_0000, 16'd100, 0, 1'b0);
  endtask

  task automatic test_back_pressure;
    core_lat = 3;
    run_frame(2, 2, 32'shFE00_0000, 32'sh0100_0000, 32'sh0080_0000, 16'd77, 2, 1'b0);
  endtask

  task automatic test_zero_size;
    int k;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      width = (c == 0) ? 11'd0 : 11'd3;
      height = (c == 0) ? 11'd3 : 11'd0;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      total++;
      if (busy !== 1'b1 || frame_done !== 1'b1 || core_start !== 1'b0 || pix_valid !== 1'b0) begin
        bad++;
        $display("FAIL zero%0d finish: busy=%b done=%b start=%b valid=%b want 1 1 0 0",
                 c, busy, frame_done, core_start, pix_valid);
      end
      k = 0;
      repeat (5) begin
        @(negedge clk);
        if (core_start !== 1'b0 || pix_valid !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) k++;
      end
      total++;
      if (k != 0) begin
        bad++;
        $display("FAIL zero%0d quiet: got %0d active cycles want 0", c, k);
      end
    end
  endtask

  task automatic test_ignore_start;
    core_lat = 2;
    run_frame(2, 2, 32'sh0123_4567, 32'shFF80_0000, 32'sh0010_0000, 16'd300, 1, 1'b1);
  endtask

  task automatic test_reset_mid;
    int k;
    core_lat = 6;
    @(negedge clk);
    width = 11'd2; height = 11'd2; x_min = 32'sh0300_0000; y_max = 32'sh0200_0000;
    step = 32'sh0040_0000; max_iter = 16'd50; frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || core_x0 !== 32'sh0300_0000) begin
      bad++;
      $display("FAIL pre-reset: busy=%b x0=%h want 1 03000000", busy, core_x0);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({core_start, core_x0, core_y0, core_max_iter, pix_valid, pix_x, pix_y, pix_iter,
         pix_last, busy, frame_done} !== '0) begin
      bad++;
      $display("FAIL async reset: busy=%b x0=%h iter=%0d want all 0", busy, core_x0, core_max_iter);
    end
    k = 0;
    repeat (3) begin
      @(negedge clk);
      if (frame_done !== 1'b0) k++;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || busy !== 1'b0) k++;
    end
    total++;
    if (k != 0) begin
      bad++;
      $display("FAIL reset abort: got %0d frame_done/busy cycles want 0", k);
    end
    core_lat = 2;
    run_frame(1, 1, 32'shFF40_0000, 32'sh0020_0000, 32'sh0001_0000, 16'd9, 0, 1'b0);
  endtask

  task automatic test_max_iter;
    core_lat = 3;
    iter_fixed = 1'b1;
    iter_val = 16'd1000;
    run_frame(3, 1, 32'shFF00_0000, 32'sh0000_0000, 32'sh0008_0000, 16'd1000, 0, 1'b1);
    iter_fixed = 1'b0;
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++) begin
      core_lat = $urandom_range(1, 4);
      run_frame($urandom_range(1, 4), $urandom_range(1, 4), DW'($urandom), DW'($urandom),
                DW'($urandom), IW'($urandom), 1, (i % 2) == 1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_2x2();
    test_back_pressure();
    test_zero_size();
    test_ignore_start();
    test_reset_mid();
    test_max_iter();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
